// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver event and host pop signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 3
);
  logic              Rx_EN;
  logic [7:0]        Rx_DATA;
  logic              Rx_VALID;
  logic              Rx_FERROR;
  logic              Rx_PERROR;
  logic              rd_en;
  logic              clr_err;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        ferr_cnt;
  logic [7:0]        perr_cnt;
  logic [7:0]        drop_cnt;

  modport master (
    output Rx_EN, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, rd_en, clr_err,
    input  rd_data, empty, full, count, overflow, ferr_cnt, perr_cnt, drop_cnt
  );

  modport slave (
    input  Rx_EN, Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, rd_en, clr_err,
    output rd_data, empty, full, count, overflow, ferr_cnt, perr_cnt, drop_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO behind a UART receiver with error/drop counters
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              v_hist_q, f_hist_q, p_hist_q;
  logic              ovf_q, ovf_d;
  logic [7:0]        ferr_q, ferr_d, perr_q, perr_d, drop_q, drop_d;
  logic              v_ev, f_ev, p_ev, err_ev, wr_req, rd_fire, wr_fire, drop;
  logic              is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == (ADDR_W+1)'(DEPTH));

  assign v_ev = bus.Rx_VALID  & ~v_hist_q;
  assign f_ev = bus.Rx_FERROR & ~f_hist_q;
  assign p_ev = bus.Rx_PERROR & ~p_hist_q;

  // An error event discards the byte of the same frame without counting it as a drop.
  assign err_ev  = bus.Rx_EN & (f_ev | p_ev);
  assign wr_req  = bus.Rx_EN & v_ev & ~err_ev;
  assign rd_fire = bus.rd_en & ~is_empty;
  assign wr_fire = wr_req & (~is_full | rd_fire);
  assign drop    = wr_req & is_full & ~rd_fire;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    drop_d   = drop_q;

    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_fire);

    if (bus.Rx_EN && f_ev && ferr_q != 8'hFF) ferr_d = ferr_q + 8'd1;
    if (bus.Rx_EN && p_ev && perr_q != 8'hFF) perr_d = perr_q + 8'd1;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    if (bus.clr_err) begin
      ovf_d  = 1'b0;
      ferr_d = 8'h00;
      perr_d = 8'h00;
      drop_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      v_hist_q <= 1'b0;
      f_hist_q <= 1'b0;
      p_hist_q <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 8'h00;
      perr_q   <= 8'h00;
      drop_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // History tracks the lines even while disabled so enabling mid-level is not an event.
      v_hist_q <= bus.Rx_VALID;
      f_hist_q <= bus.Rx_FERROR;
      p_hist_q <= bus.Rx_PERROR;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= bus.Rx_DATA;
  end

  assign bus.rd_data  = is_empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.ferr_cnt = ferr_q;
  assign bus.perr_cnt = perr_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly behind UART_receiver. It captures each validly received byte into a first-word-fall-through FIFO. It counts framing and parity error events, and gives the host a simple pop interface. This lets bytes be read at the host's pace instead of the line's pace.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2
ADDR_W, 3, log2(DEPTH); must be kept consistent with DEPTH

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
Rx_EN  input  1  when 0, receiver events are ignored (not stored, not counted)
Rx_DATA  input  8  byte from UART_receiver
Rx_VALID  input  1  receiver good-frame flag; may be a pulse or a held level
Rx_FERROR  input  1  receiver framing-error flag
Rx_PERROR  input  1  receiver parity-error flag
rd_en  input  1  pop request for the head entry
clr_err  input  1  synchronous clear of error counters and sticky flags
rd_data  output  8  head entry; 8'h00 when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_W+1  current number of entries
overflow  output  1  sticky; set when a valid byte is dropped because the FIFO is full
ferr_cnt  output  8  saturating count of framing-error events
perr_cnt  output  8  saturating count of parity-error events
drop_cnt  output  8  saturating count of dropped valid bytes

Behaviour:
- Reset (asynchronous):
  - rd/wr pointers = 0, count = 0, empty = 1, full = 0.
  - overflow = 0; all counters = 0; rd_data = 8'h00.
  - Edge-detect history registers = 0.
  - Memory contents are don't-care.
- Event detection:
  - One history register each for Rx_VALID, Rx_FERROR and Rx_PERROR.
  - An event is flag = 1 while its history = 0 (rising edge).
  - A level held for many cycles counts as exactly one event.
  - History registers update every cycle, including when Rx_EN = 0. Enabling mid-level therefore does not create a spurious event.
- Write:
  - On a valid event with Rx_EN = 1 and not full, Rx_DATA is written to mem[wr_ptr] at that edge.
  - wr_ptr increments, wrapping modulo DEPTH.
  - empty, count and rd_data reflect the new entry immediately after that edge (zero added latency).
- Error events:
  - A ferror event with Rx_EN = 1 increments ferr_cnt; a perror event increments perr_cnt.
  - Counters saturate at 8'hFF.
  - No FIFO entry is written for an error event, even if Rx_VALID also rises in the same cycle. Errors take priority: the byte is discarded and not counted as a drop.
- Read (FWFT):
  - rd_data = mem[rd_ptr] combinationally when not empty, else 8'h00.
  - rd_en = 1 and not empty at a rising edge: rd_ptr increments (wrapping) and count decrements.
  - rd_en while empty is ignored; no underflow state changes.
- Simultaneous read and write:
  - Both occur; count is unchanged.
  - When full, the pop frees a slot, so the write is accepted and nothing is dropped.
  - When empty, the write is accepted and the read is ignored (it saw empty).
- Full with no read:
  - The valid byte is dropped, overflow is set to 1, drop_cnt increments (saturating), and FIFO contents are unchanged.
- Flags: full = (count == DEPTH), empty = (count == 0). Both are derived from registered count, so there are no glitches on pointer wrap.
- clr_err:
  - At the edge it zeroes ferr_cnt, perr_cnt, drop_cnt and overflow. FIFO data is untouched.
  - If an error or drop event occurs in the same cycle, clear wins and the counter ends at 0.
- Reset mid-operation: asserting reset during a reception or with data queued discards all entries. After reset deasserts, the next valid event is stored at entry 0.
- No internal FSM beyond the pointers and counters; every path is fully synchronous except reset.

Test Plan:
1. Transmitter and receiver at baud_select 3'b111, send 8'hFA, 8'h07, 8'hC4, 8'hFF with no reads -> count = 4; then pop 4 times -> rd_data sequence FA, 07, C4, FF, empty = 1, all counters 0.
2. DEPTH = 4, send 5 bytes 8'h01–8'h05 without reading -> full = 1 after the 4th byte; overflow = 1 and drop_cnt = 1; pops return 01–04.
3. Receiver fed the inverted TxD line, send 8'hFA and 8'h07 -> FIFO stays empty; ferr_cnt + perr_cnt = 2 per the receiver's flags; clr_err -> both 0.
4. FIFO full (DEPTH = 4), assert rd_en in the same cycle as a new valid event with 8'hAA -> count stays 4, overflow stays 0, 8'hAA is the last entry popped.
5. Hold Rx_VALID high 10 cycles with Rx_DATA = 8'h55 -> exactly one entry; toggle Rx_EN 0→1 while Rx_VALID is high -> no new entry.
6. Reset asserted while 3 entries are queued and a frame is in flight -> empty = 1, count = 0, rd_data = 8'h00 immediately; next byte 8'h3C is read back as the first entry.
